// File: rtl/lcd_cmd_host.sv
// lcd_cmd_host: host-side command issuer for the LCD image controller.
// Upstream pushes 4-bit command codes into a small FIFO; this block pops
// them one at a time and presents each as a single-cycle cmd_valid strobe
// whenever the controller is not busy. A WRITE (code 0) is followed by a
// wait for done, reported as a one-cycle seq_done pulse, with a timeout
// guard. Issue count and sticky error flags are kept for status.
module lcd_cmd_host #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_cmd,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  output logic       seq_done,
  output logic [7:0] issued_cnt,
  output logic       err_code,
  output logic       err_timeout
);

  // Width of the WAIT_DONE cycle counter; it must be able to hold TIMEOUT.
  localparam int TW = $clog2(TIMEOUT + 1);

  // Largest legal command code; anything above is rejected at the input.
  localparam logic [3:0] MAX_CODE = 4'd12;

  // WRITE is the only command that is followed by a done handshake.
  localparam logic [3:0] CMD_WRITE = 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    WAIT_DONE
  } state_t;

  state_t state;
  state_t state_next;

  // FIFO storage and bookkeeping
  logic [3:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [3:0]    head;

  // Input-side qualifiers
  logic push;
  logic bad_code;

  // FSM action strobes
  logic pop;
  logic load_cmd;
  logic cnt_inc;
  logic tmo_clr;
  logic tmo_inc;
  logic tmo_set_err;
  logic seq_done_d;

  // WAIT_DONE cycle counter
  logic [TW-1:0] tmo_cnt;
  logic          tmo_last;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign head     = mem[rd_ptr];

  assign push     = in_valid && in_ready && (in_cmd <= MAX_CODE);
  assign bad_code = in_valid && in_ready && (in_cmd >  MAX_CODE);

  assign tmo_last = (tmo_cnt == TW'(TIMEOUT - 1));

  // FIFO storage write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count as is.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!busy && !empty) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (cmd == CMD_WRITE) begin
          state_next = WAIT_DONE;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (done || tmo_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-state action strobes; done wins over a timeout in the same cycle.
  always_comb begin
    pop         = 1'b0;
    load_cmd    = 1'b0;
    cnt_inc     = 1'b0;
    tmo_clr     = 1'b0;
    tmo_inc     = 1'b0;
    tmo_set_err = 1'b0;
    seq_done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!busy && !empty) begin
          pop      = 1'b1;
          load_cmd = 1'b1;
        end
      end
      ISSUE: begin
        cnt_inc = 1'b1;
      end
      HOLD: begin
        if (cmd == CMD_WRITE) begin
          tmo_clr = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          seq_done_d = 1'b1;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_last) begin
            tmo_set_err = 1'b1;
          end
        end
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  // Registered controller-facing outputs; cmd keeps its last issued value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      cmd_valid <= load_cmd;
      seq_done  <= seq_done_d;
      if (load_cmd) begin
        cmd <= head;
      end
    end
  end

  // Issue counter, wrapping naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issued_cnt <= '0;
    end else if (cnt_inc) begin
      issued_cnt <= issued_cnt + 8'd1;
    end
  end

  // WAIT_DONE cycle counter, restarted on entry from HOLD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
    end else if (tmo_inc) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_code    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (bad_code) begin
        err_code <= 1'b1;
      end
      if (tmo_set_err) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_cmd_host.sv
// tb_lcd_cmd_host: self-checking bench for lcd_cmd_host.
// A vector table covers reset, basic issue latency and illegal codes;
// hand-written sequences cover busy deferral, WRITE/done, FIFO full and
// the WAIT_DONE timeout with a mid-sequence reset.
module tb_lcd_cmd_host;

  logic       clk;
  logic       reset;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       seq_done;
  logic [7:0] issued_cnt;
  logic       err_code;
  logic       err_timeout;

  int checks;
  int failures;

  // Observations gathered by run_cycles
  int         strobe_cyc[$];
  logic [3:0] strobe_cmd[$];
  int         seq_done_seen;
  int         err_to_first;

  typedef struct {
    logic       rst_v;
    logic [3:0] c;
    logic       v;
    logic       b;
    logic       d;
    logic       e_ready;
    logic       e_cv;
    logic [3:0] e_cmd;
    logic [7:0] e_cnt;
    logic       e_err;
    logic       e_seq;
  } vec_t;

  vec_t vecs[12];

  lcd_cmd_host #(
    .DEPTH(8),
    .AW(3),
    .TIMEOUT(256)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_cmd(in_cmd),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .busy(busy),
    .done(done),
    .seq_done(seq_done),
    .issued_cnt(issued_cnt),
    .err_code(err_code),
    .err_timeout(err_timeout)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus thread.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle of inputs from a negedge, step one rising edge, return at the next negedge.
  task automatic applyStimulus(input logic rst_v, input logic [3:0] c, input logic v,
                               input logic b, input logic d);
    reset    = rst_v;
    in_cmd   = c;
    in_valid = v;
    busy     = b;
    done     = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Two reset cycles, leaving reset released for the next stimulus.
  task automatic do_reset();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Idle n cycles with the given busy level, logging strobes, seq_done and the first err_timeout.
  task automatic run_cycles(input int n, input logic b);
    strobe_cyc.delete();
    strobe_cmd.delete();
    seq_done_seen = 0;
    err_to_first  = -1;
    for (int i = 1; i <= n; i++) begin
      applyStimulus(1'b1, 4'd0, 1'b0, b, 1'b0);
      if (cmd_valid) begin
        strobe_cyc.push_back(i);
        strobe_cmd.push_back(cmd);
      end
      if (seq_done) seq_done_seen++;
      if (err_timeout && err_to_first < 0) err_to_first = i;
    end
  endtask

  // Step idle cycles (busy low) until a strobe is visible, bounded by limit.
  task automatic wait_strobe(input string name, input logic [3:0] exp_cmd, input int limit);
    bit found;
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (cmd_valid) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput({name, "_found"}, 32'(found), 32'd1);
    checkOutput({name, "_cmd"}, 32'(cmd), 32'(exp_cmd));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    in_cmd   = 4'd0;
    in_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    @(negedge clk);

    // ---- Reset state ----
    do_reset();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_cmd", 32'(cmd), 32'd0);
    checkOutput("rst_issued", 32'(issued_cnt), 32'd0);
    checkOutput("rst_err_code", 32'(err_code), 32'd0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
    checkOutput("rst_seq_done", 32'(seq_done), 32'd0);

    // ---- Table: issue latency, ignored done, illegal codes ----
    //           rst c      v     b     d     ready cv    cmd    cnt    err   seq
    vecs[0]  = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 8'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 8'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 8'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 8'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 8'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 8'd1, 1'b1, 1'b0};

    for (int r = 0; r < 12; r++) begin
      applyStimulus(vecs[r].rst_v, vecs[r].c, vecs[r].v, vecs[r].b, vecs[r].d);
      checkOutput($sformatf("vec%0d_in_ready", r), 32'(in_ready), 32'(vecs[r].e_ready));
      checkOutput($sformatf("vec%0d_cmd_valid", r), 32'(cmd_valid), 32'(vecs[r].e_cv));
      checkOutput($sformatf("vec%0d_cmd", r), 32'(cmd), 32'(vecs[r].e_cmd));
      checkOutput($sformatf("vec%0d_issued", r), 32'(issued_cnt), 32'(vecs[r].e_cnt));
      checkOutput($sformatf("vec%0d_err_code", r), 32'(err_code), 32'(vecs[r].e_err));
      checkOutput($sformatf("vec%0d_seq_done", r), 32'(seq_done), 32'(vecs[r].e_seq));
      checkOutput($sformatf("vec%0d_err_timeout", r), 32'(err_timeout), 32'd0);
    end
    run_cycles(6, 1'b0);
    checkOutput("illegal_no_more_strobes", 32'(strobe_cyc.size()), 32'd0);
    checkOutput("illegal_issued", 32'(issued_cnt), 32'd1);
    checkOutput("illegal_err_sticky", 32'(err_code), 32'd1);

    // ---- Busy defers issue, then three strobes 3 cycles apart ----
    do_reset();
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd4, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
    run_cycles(5, 1'b1);
    checkOutput("busy_no_strobe", 32'(strobe_cyc.size()), 32'd0);
    run_cycles(12, 1'b0);
    checkOutput("busy_strobe_count", 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() == 3) begin
      checkOutput("busy_first_cycle", 32'(strobe_cyc[0]), 32'd1);
      checkOutput("busy_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd3);
      checkOutput("busy_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd3);
      checkOutput("busy_cmd0", 32'(strobe_cmd[0]), 32'd3);
      checkOutput("busy_cmd1", 32'(strobe_cmd[1]), 32'd4);
      checkOutput("busy_cmd2", 32'(strobe_cmd[2]), 32'd5);
    end
    checkOutput("busy_issued", 32'(issued_cnt), 32'd3);

    // ---- WRITE followed by done after a long busy period ----
    do_reset();
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    wait_strobe("wr_first", 4'd5, 5);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    wait_strobe("wr_write", 4'd0, 6);
    run_cycles(64, 1'b1);
    checkOutput("wr_no_early_seq_done", 32'(seq_done_seen), 32'd0);
    checkOutput("wr_no_strobe_waiting", 32'(strobe_cyc.size()), 32'd0);
    checkOutput("wr_issued", 32'(issued_cnt), 32'd2);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("wr_seq_done_pulse", 32'(seq_done), 32'd1);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("wr_seq_done_low", 32'(seq_done), 32'd0);
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    wait_strobe("wr_after", 4'd2, 5);
    checkOutput("wr_err_timeout", 32'(err_timeout), 32'd0);

    // ---- FIFO full: 9 pushes while busy, 8 accepted and drained in order ----
    do_reset();
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("full_ready_before%0d", i), 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
      applyStimulus(1'b1, 4'(i + 1), 1'b1, 1'b1, 1'b0);
    end
    checkOutput("full_ready_after9", 32'(in_ready), 32'd0);
    run_cycles(30, 1'b0);
    checkOutput("full_strobe_count", 32'(strobe_cyc.size()), 32'd8);
    for (int i = 0; i < strobe_cmd.size() && i < 8; i++) begin
      checkOutput($sformatf("full_order%0d", i), 32'(strobe_cmd[i]), 32'(i + 1));
    end
    checkOutput("full_ready_drained", 32'(in_ready), 32'd1);
    checkOutput("full_issued", 32'(issued_cnt), 32'd8);

    // ---- WRITE with no done: timeout, then the next command issues ----
    do_reset();
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    wait_strobe("to_write", 4'd0, 5);
    run_cycles(300, 1'b0);
    checkOutput("to_err_first_cycle", 32'(err_to_first), 32'd258);
    checkOutput("to_no_seq_done", 32'(seq_done_seen), 32'd0);
    checkOutput("to_strobe_count", 32'(strobe_cyc.size()), 32'd1);
    if (strobe_cyc.size() == 1) begin
      checkOutput("to_next_cycle", 32'(strobe_cyc[0]), 32'd259);
      checkOutput("to_next_cmd", 32'(strobe_cmd[0]), 32'd6);
    end
    checkOutput("to_issued", 32'(issued_cnt), 32'd2);

    // ---- Repeat run, reset mid-WAIT_DONE clears everything ----
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    wait_strobe("mid_write", 4'd0, 5);
    run_cycles(20, 1'b0);
    checkOutput("mid_err_sticky", 32'(err_timeout), 32'd1);
    checkOutput("mid_waiting", 32'(strobe_cyc.size()), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("mid_rst_cmd", 32'(cmd), 32'd0);
    checkOutput("mid_rst_issued", 32'(issued_cnt), 32'd0);
    checkOutput("mid_rst_err_timeout", 32'(err_timeout), 32'd0);
    checkOutput("mid_rst_err_code", 32'(err_code), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    run_cycles(10, 1'b0);
    checkOutput("mid_fifo_empty", 32'(strobe_cyc.size()), 32'd0);
    checkOutput("mid_err_stays_clear", 32'(err_to_first), 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
